// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage rv32i pipeline with split I/D completion.
// Define PIPE_CTRL_PERF_EN to add stall/load-use/flush performance counters.
module pipeline_ctrl #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              imem_read_i,
   input  logic              imem_resp,
   input  logic [DATA_W-1:0] imem_rdata,
   output logic              imem_read_o,
   output logic [DATA_W-1:0] instr_o,
   input  logic              dmem_read_i,
   input  logic              dmem_write_i,
   input  logic              dmem_resp,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic              dmem_read_o,
   output logic              dmem_write_o,
   output logic [DATA_W-1:0] rdata_o,
   input  logic              ex_is_load,
   input  logic [4:0]        ex_rd,
   input  logic [4:0]        id_rs1,
   input  logic [4:0]        id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic              br_taken_ex,
   output logic              stall_pc,
   output logic              stall_if_id,
   output logic              stall_id_ex,
   output logic              stall_ex_mem,
   output logic              stall_mem_wb,
   output logic              flush_if_id,
   output logic              flush_id_ex,
   output logic              pc_redirect
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [31:0]       perf_stall_cyc,
   output logic [31:0]       perf_lu_cnt,
   output logic [31:0]       perf_flush_cnt
`endif
);

   logic              i_done_q, i_done_d;
   logic              d_done_q, d_done_d;
   logic [DATA_W-1:0] ibuf_q, ibuf_d;
   logic [DATA_W-1:0] dbuf_q, dbuf_d;

   logic i_done, d_done;
   logic mem_req;
   logic fetch_busy, mem_busy, gstall;
   logic hit1, hit2, lu;
   logic i_set, d_set;
   logic m_gstall, m_br, m_lu;

   // Flags are ignored while reset is held so gated ports pass straight through.
   assign i_done = i_done_q & ~rst;
   assign d_done = d_done_q & ~rst;

   assign mem_req    = dmem_read_i | dmem_write_i;
   assign fetch_busy = imem_read_i & ~imem_resp & ~i_done;
   assign mem_busy   = mem_req & ~dmem_resp & ~d_done;
   assign gstall     = fetch_busy | mem_busy;

   assign hit1 = id_use_rs1 & (id_rs1 == ex_rd);
   assign hit2 = id_use_rs2 & (id_rs2 == ex_rd);
   assign lu   = ex_is_load & (ex_rd != 5'd0) & (hit1 | hit2);

   assign i_set = imem_read_i & imem_resp & ~i_done & mem_busy;
   assign d_set = mem_req & dmem_resp & ~d_done & fetch_busy;

   assign m_gstall = ~rst & gstall;
   assign m_br     = ~rst & ~gstall & br_taken_ex;
   assign m_lu     = ~rst & ~gstall & ~br_taken_ex & lu;

   assign imem_read_o  = imem_read_i & ~i_done;
   assign dmem_read_o  = dmem_read_i & ~d_done;
   assign dmem_write_o = dmem_write_i & ~d_done;

   assign instr_o = i_done ? ibuf_q : imem_rdata;
   assign rdata_o = d_done ? dbuf_q : dmem_rdata;

   always_comb begin
      i_done_d = i_done_q;
      ibuf_d   = ibuf_q;
      d_done_d = d_done_q;
      dbuf_d   = dbuf_q;
      if (!gstall) begin
         i_done_d = 1'b0;
         d_done_d = 1'b0;
      end else begin
         if (i_set) begin
            i_done_d = 1'b1;
            ibuf_d   = imem_rdata;
         end
         if (d_set) begin
            d_done_d = 1'b1;
            dbuf_d   = dmem_rdata;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         i_done_q <= 1'b0;
         d_done_q <= 1'b0;
         ibuf_q   <= '0;
         dbuf_q   <= '0;
      end else begin
         i_done_q <= i_done_d;
         d_done_q <= d_done_d;
         ibuf_q   <= ibuf_d;
         dbuf_q   <= dbuf_d;
      end
   end

   always_comb begin
      stall_pc     = 1'b0;
      stall_if_id  = 1'b0;
      stall_id_ex  = 1'b0;
      stall_ex_mem = 1'b0;
      stall_mem_wb = 1'b0;
      flush_if_id  = 1'b0;
      flush_id_ex  = 1'b0;
      pc_redirect  = 1'b0;
      unique case (1'b1)
         m_gstall: begin
            stall_pc     = 1'b1;
            stall_if_id  = 1'b1;
            stall_id_ex  = 1'b1;
            stall_ex_mem = 1'b1;
            stall_mem_wb = 1'b1;
         end
         m_br: begin
            pc_redirect = 1'b1;
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
         end
         m_lu: begin
            stall_pc    = 1'b1;
            stall_if_id = 1'b1;
            flush_id_ex = 1'b1;
         end
         default: ;
      endcase
   end

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stall_cyc_q, lu_cnt_q, flush_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cyc_q <= '0;
         lu_cnt_q    <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cyc_q <= stall_cyc_q + {31'd0, m_gstall};
         lu_cnt_q    <= lu_cnt_q + {31'd0, m_lu};
         flush_cnt_q <= flush_cnt_q + {31'd0, m_br};
      end
   end

   assign perf_stall_cyc = stall_cyc_q;
   assign perf_lu_cnt    = lu_cnt_q;
   assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: vector table plus miss/split/branch/reset sequences.
module tb_pipeline_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_read_i, imem_resp;
   logic [31:0] imem_rdata;
   logic        imem_read_o;
   logic [31:0] instr_o;
   logic        dmem_read_i, dmem_write_i, dmem_resp;
   logic [31:0] dmem_rdata;
   logic        dmem_read_o, dmem_write_o;
   logic [31:0] rdata_o;
   logic        ex_is_load;
   logic [4:0]  ex_rd, id_rs1, id_rs2;
   logic        id_use_rs1, id_use_rs2, br_taken_ex;
   logic        stall_pc, stall_if_id, stall_id_ex, stall_ex_mem, stall_mem_wb;
   logic        flush_if_id, flush_id_ex, pc_redirect;
`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] perf_stall_cyc, perf_lu_cnt, perf_flush_cnt;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   pipeline_ctrl #(.DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .imem_read_i(imem_read_i), .imem_resp(imem_resp),
      .imem_rdata(imem_rdata), .imem_read_o(imem_read_o),
      .instr_o(instr_o),
      .dmem_read_i(dmem_read_i), .dmem_write_i(dmem_write_i),
      .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
      .dmem_read_o(dmem_read_o), .dmem_write_o(dmem_write_o),
      .rdata_o(rdata_o),
      .ex_is_load(ex_is_load), .ex_rd(ex_rd),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .br_taken_ex(br_taken_ex),
      .stall_pc(stall_pc), .stall_if_id(stall_if_id),
      .stall_id_ex(stall_id_ex), .stall_ex_mem(stall_ex_mem),
      .stall_mem_wb(stall_mem_wb),
      .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
      .pc_redirect(pc_redirect)
`ifdef PIPE_CTRL_PERF_EN
      ,
      .perf_stall_cyc(perf_stall_cyc),
      .perf_lu_cnt(perf_lu_cnt),
      .perf_flush_cnt(perf_flush_cnt)
`endif
   );

   typedef struct packed {
      logic       ir, irsp, dr, dw, drsp, ld;
      logic [4:0] rd, rs1, rs2;
      logic       u1, u2, br;
      logic [7:0] ctl;
      logic [2:0] gate;
   } vec_t;

   vec_t vec [18];

   function automatic logic [7:0] ctl_now();
      return {stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
              stall_mem_wb, flush_if_id, flush_id_ex, pc_redirect};
   endfunction

   function automatic logic [2:0] gate_now();
      return {imem_read_o, dmem_read_o, dmem_write_o};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic idle();
      imem_read_i = 0; imem_resp = 0; imem_rdata = '0;
      dmem_read_i = 0; dmem_write_i = 0; dmem_resp = 0; dmem_rdata = '0;
      ex_is_load = 0; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;
      id_use_rs1 = 0; id_use_rs2 = 0; br_taken_ex = 0;
   endtask

   // Drive on negedge, sample 2ns later (well before the next posedge).
   task automatic cyc();
      @(negedge clk);
   endtask

   initial begin
      vec[0]  = '{0,0,0,0,0,0, 5'd0,5'd0,5'd0, 0,0,0, 8'b00000000, 3'b000};
      vec[1]  = '{1,0,0,0,0,0, 5'd0,5'd0,5'd0, 0,0,0, 8'b11111000, 3'b100};
      vec[2]  = '{1,1,0,0,0,0, 5'd0,5'd0,5'd0, 0,0,0, 8'b00000000, 3'b100};
      vec[3]  = '{0,0,1,0,0,0, 5'd0,5'd0,5'd0, 0,0,0, 8'b11111000, 3'b010};
      vec[4]  = '{0,0,0,1,0,0, 5'd0,5'd0,5'd0, 0,0,0, 8'b11111000, 3'b001};
      vec[5]  = '{0,0,0,1,1,0, 5'd0,5'd0,5'd0, 0,0,0, 8'b00000000, 3'b001};
      vec[6]  = '{0,0,0,0,0,1, 5'd5,5'd0,5'd5, 0,1,0, 8'b11000010, 3'b000};
      vec[7]  = '{0,0,0,0,0,1, 5'd0,5'd0,5'd0, 1,1,0, 8'b00000000, 3'b000};
      vec[8]  = '{0,0,0,0,0,1, 5'd5,5'd5,5'd3, 0,1,0, 8'b00000000, 3'b000};
      vec[9]  = '{0,0,0,0,0,1, 5'd7,5'd7,5'd0, 1,0,0, 8'b11000010, 3'b000};
      vec[10] = '{0,0,0,0,0,0, 5'd5,5'd0,5'd5, 0,1,0, 8'b00000000, 3'b000};
      vec[11] = '{0,0,0,0,0,1, 5'd5,5'd0,5'd5, 0,1,1, 8'b00000111, 3'b000};
      vec[12] = '{0,0,0,0,0,0, 5'd0,5'd0,5'd0, 0,0,1, 8'b00000111, 3'b000};
      vec[13] = '{1,0,0,0,0,0, 5'd0,5'd0,5'd0, 0,0,1, 8'b11111000, 3'b100};
      vec[14] = '{0,0,1,0,0,1, 5'd5,5'd0,5'd5, 0,1,0, 8'b11111000, 3'b010};
      vec[15] = '{1,1,1,0,1,0, 5'd0,5'd0,5'd0, 0,0,0, 8'b00000000, 3'b110};
      vec[16] = '{1,0,1,0,0,0, 5'd0,5'd0,5'd0, 0,0,0, 8'b11111000, 3'b110};
      vec[17] = '{0,0,0,0,0,0, 5'd0,5'd0,5'd0, 0,0,0, 8'b00000000, 3'b000};

      idle();
      rst = 1;
      cyc(); #2;
      chk("rst_ctl", {24'd0, ctl_now()}, 32'd0);
      imem_read_i = 1; dmem_write_i = 1;
      #1;
      chk("rst_gate", {29'd0, gate_now()}, 32'b101);
      cyc();
      idle();
      rst = 0;
      #2;
`ifdef PIPE_CTRL_PERF_EN
      chk("perf_stall0", perf_stall_cyc, 32'd0);
      chk("perf_lu0", perf_lu_cnt, 32'd0);
      chk("perf_flush0", perf_flush_cnt, 32'd0);
`endif

      for (int i = 0; i < 18; i++) begin
         cyc();
         imem_read_i = vec[i].ir; imem_resp = vec[i].irsp;
         dmem_read_i = vec[i].dr; dmem_write_i = vec[i].dw;
         dmem_resp = vec[i].drsp; ex_is_load = vec[i].ld;
         ex_rd = vec[i].rd; id_rs1 = vec[i].rs1; id_rs2 = vec[i].rs2;
         id_use_rs1 = vec[i].u1; id_use_rs2 = vec[i].u2;
         br_taken_ex = vec[i].br;
         imem_rdata = 32'h1000_0000 + i;
         dmem_rdata = 32'h2000_0000 + i;
         #2;
         chk($sformatf("vec%0d_ctl", i), {24'd0, ctl_now()}, {24'd0, vec[i].ctl});
         chk($sformatf("vec%0d_gate", i), {29'd0, gate_now()}, {29'd0, vec[i].gate});
         chk($sformatf("vec%0d_instr", i), instr_o, 32'h1000_0000 + i);
         chk($sformatf("vec%0d_rdata", i), rdata_o, 32'h2000_0000 + i);
      end

      // Fetch miss: three stalled cycles then release on the response.
      for (int c = 0; c < 4; c++) begin
         cyc();
         idle();
         imem_read_i = 1;
         imem_resp = (c == 3);
         imem_rdata = (c == 3) ? 32'h1234_5678 : 32'h0;
         #2;
         chk($sformatf("fmiss_c%0d_ctl", c), {24'd0, ctl_now()},
             (c == 3) ? 32'd0 : 32'hF8);
         if (c == 3) chk("fmiss_instr", instr_o, 32'h1234_5678);
      end

      // Split completion: dmem resp at cycle 2, imem resp at cycle 5.
      for (int c = 0; c < 7; c++) begin
         cyc();
         idle();
         imem_read_i = (c < 6);
         dmem_read_i = 1;
         dmem_resp = (c == 2) || (c == 6);
         imem_resp = (c == 5);
         imem_rdata = (c == 5) ? 32'hCAFE_0001 : 32'h0;
         dmem_rdata = (c == 2) ? 32'hDEAD_BEEF :
                      (c == 6) ? 32'h1111_1111 : 32'h0BAD_0BAD;
         #2;
         if (c < 5)
            chk($sformatf("split_c%0d_ctl", c), {24'd0, ctl_now()}, 32'hF8);
         if (c >= 3 && c <= 5) begin
            chk($sformatf("split_c%0d_drd", c), {31'd0, dmem_read_o}, 32'd0);
            chk($sformatf("split_c%0d_rdata", c), rdata_o, 32'hDEAD_BEEF);
         end
         if (c == 2) chk("split_c2_drd", {31'd0, dmem_read_o}, 32'd1);
         if (c == 5) begin
            chk("split_rel_ctl", {24'd0, ctl_now()}, 32'd0);
            chk("split_rel_instr", instr_o, 32'hCAFE_0001);
         end
         if (c == 6) begin
            chk("split_after_drd", {31'd0, dmem_read_o}, 32'd1);
            chk("split_after_rdata", rdata_o, 32'h1111_1111);
         end
      end

      // Taken branch held in EX across a 4-cycle D-miss.
      for (int c = 0; c < 5; c++) begin
         cyc();
         idle();
         br_taken_ex = 1;
         dmem_read_i = 1;
         dmem_resp = (c == 4);
         #2;
         chk($sformatf("brmiss_c%0d_ctl", c), {24'd0, ctl_now()},
             (c == 4) ? 32'h07 : 32'hF8);
      end

      // Reset with i_done set discards the buffered instruction.
      cyc();
      idle();
      imem_read_i = 1; imem_resp = 1; imem_rdata = 32'hAAAA_5555;
      dmem_read_i = 1;
      cyc();
      imem_resp = 0; imem_rdata = 32'h0;
      #2;
      chk("rst_pre_instr", instr_o, 32'hAAAA_5555);
      chk("rst_pre_ird", {31'd0, imem_read_o}, 32'd0);
      cyc();
      rst = 1;
      imem_rdata = 32'h5555_AAAA;
      #2;
      chk("rst_mid_ctl", {24'd0, ctl_now()}, 32'd0);
      chk("rst_mid_ird", {31'd0, imem_read_o}, 32'd1);
      cyc();
      rst = 0;
      dmem_read_i = 0;
      imem_rdata = 32'h0F0F_0F0F;
      #2;
      chk("rst_post_instr", instr_o, 32'h0F0F_0F0F);
      chk("rst_post_ird", {31'd0, imem_read_o}, 32'd1);
      chk("rst_post_ctl", {24'd0, ctl_now()}, 32'hF8);
`ifdef PIPE_CTRL_PERF_EN
      chk("perf_stall_rst", perf_stall_cyc, 32'd0);
      chk("perf_lu_rst", perf_lu_cnt, 32'd0);
      chk("perf_flush_rst", perf_flush_cnt, 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the 5-stage rv32i pipeline. It observes instruction-fetch and data-memory handshakes, load-use hazards and EX-stage branch resolution, then drives the `stall`/`flush` inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It tracks split completion when both memories are busy, and holds early-arriving read data until the pipeline advances. It sits beside the datapath between the stage registers and the I/D cache ports.

## Interface
- `DATA_W`, 32, width of the instruction and load-data buffers.
- `clk` in 1, pipeline clock.
- `rst` in 1, synchronous, active-high reset.
- `imem_read_i` in 1, fetch request from the IF stage.
- `imem_resp` in 1, I-cache response; valid for one cycle.
- `imem_rdata` in DATA_W, I-cache data, valid with `imem_resp`.
- `imem_read_o` out 1, gated fetch request to the I-cache.
- `instr_o` out DATA_W, instruction presented to IF/ID.
- `dmem_read_i`, `dmem_write_i` in 1 each, MEM-stage access requests.
- `dmem_resp` in 1, D-cache response; valid for one cycle.
- `dmem_rdata` in DATA_W, D-cache load data.
- `dmem_read_o`, `dmem_write_o` out 1 each, gated requests to the D-cache.
- `rdata_o` out DATA_W, load data presented to MEM/WB.
- `ex_is_load` in 1, the EX-stage instruction is a load.
- `ex_rd` in 5, EX-stage destination register.
- `id_rs1`, `id_rs2` in 5 each, ID-stage source registers.
- `id_use_rs1`, `id_use_rs2` in 1 each, the ID-stage instruction reads the source.
- `br_taken_ex` in 1, EX resolved a taken branch or jump.
- `stall_pc`, `stall_if_id`, `stall_id_ex`, `stall_ex_mem`, `stall_mem_wb` out 1 each, register hold.
- `flush_if_id`, `flush_id_ex` out 1 each, load a bubble into the register.
- `pc_redirect` out 1, PC loads the branch target this cycle.

## Operation
- Done flags: `i_done` and `d_done`, both reset to 0.
- `fetch_busy` = `imem_read_i` & ~`imem_resp` & ~`i_done`.
- `mem_busy` = (`dmem_read_i` | `dmem_write_i`) & ~`dmem_resp` & ~`d_done`.
- `gstall` = `fetch_busy` | `mem_busy`. When asserted, all five stall outputs are 1, both flush outputs are 0 and `pc_redirect` is 0.
- Split completion:
  - `imem_resp` while `mem_busy`: set `i_done` and latch `imem_rdata` into `ibuf`.
  - `dmem_resp` while `fetch_busy`: set `d_done` and latch into `dbuf`.
  - Both flags clear on the first cycle `gstall`=0.
- Request gating:
  - `imem_read_o` = `imem_read_i` & ~`i_done`.
  - `dmem_*_o` = `dmem_*_i` & ~`d_done`.
  - A completed access is never reissued.
- Data muxing:
  - `instr_o` = `i_done` ? `ibuf` : `imem_rdata`.
  - `rdata_o` = `d_done` ? `dbuf` : `dmem_rdata`.
- Load-use: `lu` = `ex_is_load` & (`ex_rd`≠0) & ((`id_use_rs1` & `id_rs1`==`ex_rd`) | (`id_use_rs2` & `id_rs2`==`ex_rd`)). When `lu` & ~`gstall` & ~`br_taken_ex`:
  - `stall_pc`=1, `stall_if_id`=1, `flush_id_ex`=1.
  - EX/MEM and MEM/WB advance.
- Branch: when `br_taken_ex` & ~`gstall`:
  - `pc_redirect`=1, `flush_if_id`=1, `flush_id_ex`=1.
  - Branch overrides `lu`, because the ID instruction is wrong-path.
- Priority: `gstall` > branch > load-use > run. In run, all outputs are 0.
- Redirect during a stall: `br_taken_ex` stays asserted while EX is held. The redirect fires on the release cycle; no extra state is needed.

## Timing
- Stall, flush and redirect outputs are combinational from the inputs and the done flags; there is no added latency.
- The buffers and done flags update on `posedge clk`.
- `imem_resp` and `dmem_resp` in the same cycle: `gstall`=0 and the pipeline advances that cycle; no flag is set.
- A response arriving while the other access is not busy: pass-through, no flag set.
- Reset:
  - All flags, buffers and perf counters are 0.
  - During `rst`, all stall outputs are 0.
  - Gated outputs follow their inputs.
  - A reset mid-wait discards buffered data.

## Configuration
- `PIPE_CTRL_PERF_EN` defined adds three 32-bit wrapping counter outputs, each reset to 0:
  - `perf_stall_cyc`: +1 per cycle with `gstall`.
  - `perf_lu_cnt`: +1 per load-use bubble.
  - `perf_flush_cnt`: +1 per `pc_redirect`.
- `PIPE_CTRL_PERF_EN` undefined: these ports and their logic are absent.

## Test plan
- Fetch miss:
  - Stimulus: `imem_read_i`=1, `imem_resp` held low for 3 cycles.
  - Required: all stalls=1 for 3 cycles, then 0 in the `imem_resp` cycle, with `instr_o`=`imem_rdata`.
- Split completion:
  - Stimulus: fetch and load both busy; `dmem_resp` with 0xDEADBEEF at cycle 2; `imem_resp` at cycle 5.
  - Required: `d_done`=1 from cycle 3; `dmem_read_o`=0 during cycles 3–5; `rdata_o`=0xDEADBEEF at cycle 5; stalls release at cycle 5.
- Load-use:
  - Stimulus: `ex_is_load`=1, `ex_rd`=5, `id_rs2`=5, `id_use_rs2`=1.
  - Required: `stall_pc`=`stall_if_id`=`flush_id_ex`=1 for one cycle.
  - Also: with `ex_rd`=0 there is no bubble.
- Branch with load-use:
  - Stimulus: `br_taken_ex`=1 together with the load-use case above.
  - Required: `pc_redirect`=`flush_if_id`=`flush_id_ex`=1; `stall_pc`=0.
- Branch during a D-miss:
  - Stimulus: `br_taken_ex`=1 with `mem_busy` lasting 4 cycles.
  - Required: `pc_redirect`=0 for 4 cycles, then 1 on the release cycle.
- Reset:
  - Stimulus: assert `rst` with `i_done`=1.
  - Required: `i_done`=0 and `instr_o` follows `imem_rdata` next cycle.
  - Also: with `PIPE_CTRL_PERF_EN` defined, all counters read 0.
